// File: rtl/startup_display_engine_pkg.sv
// Purpose : shared constants, display pattern table and majority-vote helper for the startup display.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package startup_display_engine_pkg;

    localparam int          NPAT_DEF    = 8;
    localparam int          LED_W_DEF   = 8;
    // Dwell per pattern in timer ticks; the sequencing FSM compares TMR against this.
    localparam logic [15:0] DWELL_TICKS = 16'hBB8;
    localparam int          PAT_TBL_N   = 8;

    // Display pattern table. Indices past the table wrap, so NPAT > PAT_TBL_N repeats it.
    function automatic logic [31:0] pat_word(input int unsigned idx);
        logic [31:0] w;
        case (idx % PAT_TBL_N)
            0:       w = 32'h81;
            1:       w = 32'h42;
            2:       w = 32'h24;
            3:       w = 32'h18;
            4:       w = 32'h3C;
            5:       w = 32'h7E;
            6:       w = 32'hFF;
            default: w = 32'hA5;
        endcase
        return w;
    endfunction

    // Bitwise 2-of-3 vote. Callers zero-extend narrower values and cast the result back.
    function automatic logic [31:0] maj3(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/startup_pattern_rom.sv
// Purpose : synchronous-read pattern ROM; ADR=k (1..NPAT) returns table word k-1.
// Latency : 1 cycle from adr to rom_q.
// Backpressure: none; reads every cycle. Ports: CLK, RST (async high), adr, rom_q.
module startup_pattern_rom
    import startup_display_engine_pkg::*;
#(
    parameter int NPAT  = NPAT_DEF,
    parameter int LED_W = LED_W_DEF,
    parameter int AW    = $clog2(NPAT + 2)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    adr,
    output logic [LED_W-1:0] rom_q
);

    logic [LED_W-1:0] word;

    // Out-of-range addresses (blank and end-of-table) read as zero; consumers ignore them.
    always_comb begin
        word = '0;
        if (adr != '0 && 32'(adr) <= NPAT) begin
            word = LED_W'(pat_word(32'(adr) - 32'd1));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rom_q <= '0;
        end else begin
            rom_q <= word;
        end
    end

endmodule

// File: rtl/startup_display_engine.sv
// Purpose : responder side of the startup LED display: tick timer, pattern address, ROM, LED drive; all
//           state triplicated and majority-voted. Ports: CLK, RST, CLEAR, DISP, LOAD_PAT, NXT_ADR, RST_TMR in;
//           TMR, DONE, LEDS out. Latency: strobes act on the next edge; LEDS lags pat_reg/DISP by one cycle.
// Backpressure: none; strobes are level-sampled every edge and a held strobe acts once per cycle.
module startup_display_engine
    import startup_display_engine_pkg::*;
#(
    parameter int NPAT     = NPAT_DEF,
    parameter int LED_W    = LED_W_DEF,   // voting helper limits this to 32
    parameter int TICK_DIV = 40000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLEAR,
    input  logic             DISP,
    input  logic             LOAD_PAT,
    input  logic             NXT_ADR,
    input  logic             RST_TMR,
    output logic [15:0]      TMR,
    output logic             DONE,
    output logic [LED_W-1:0] LEDS
);

    localparam int            AW       = $clog2(NPAT + 2);
    localparam int            PW       = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADR_END  = AW'(NPAT + 1);

    // Three copies of every state register; the attributes stop synthesis from merging them.
    (* keep = "true", dont_touch = "true" *) logic [15:0]      tmr_q  [3];
    (* keep = "true", dont_touch = "true" *) logic [PW-1:0]    psc_q  [3];
    (* keep = "true", dont_touch = "true" *) logic [AW-1:0]    adr_q  [3];
    (* keep = "true", dont_touch = "true" *) logic             done_q [3];
    (* keep = "true", dont_touch = "true" *) logic [LED_W-1:0] rom_q  [3];
    (* keep = "true", dont_touch = "true" *) logic [LED_W-1:0] pat_q  [3];
    (* keep = "true", dont_touch = "true" *) logic [LED_W-1:0] leds_q [3];

    logic [15:0]      tmr_v,  tmr_n;
    logic [PW-1:0]    psc_v,  psc_n;
    logic [AW-1:0]    adr_v,  adr_n;
    logic             done_v, done_n;
    logic [LED_W-1:0] rom_v;
    logic [LED_W-1:0] pat_v,  pat_n;
    logic [LED_W-1:0] leds_v, leds_n;

    // Voted view of the state; both the outputs and every copy's next value come from here,
    // so a single upset copy is overwritten on the following edge.
    always_comb begin
        tmr_v  = 16'(maj3(32'(tmr_q[0]), 32'(tmr_q[1]), 32'(tmr_q[2])));
        psc_v  = PW'(maj3(32'(psc_q[0]), 32'(psc_q[1]), 32'(psc_q[2])));
        adr_v  = AW'(maj3(32'(adr_q[0]), 32'(adr_q[1]), 32'(adr_q[2])));
        done_v = 1'(maj3(32'(done_q[0]), 32'(done_q[1]), 32'(done_q[2])));
        rom_v  = LED_W'(maj3(32'(rom_q[0]), 32'(rom_q[1]), 32'(rom_q[2])));
        pat_v  = LED_W'(maj3(32'(pat_q[0]), 32'(pat_q[1]), 32'(pat_q[2])));
        leds_v = LED_W'(maj3(32'(leds_q[0]), 32'(leds_q[1]), 32'(leds_q[2])));
    end

    always_comb begin
        tmr_n  = tmr_v;
        psc_n  = psc_v;
        adr_n  = adr_v;
        pat_n  = pat_v;
        // Prescaler wraps every TICK_DIV edges; TMR steps on the wrap and sticks at all-ones.
        if (RST_TMR) begin
            psc_n = '0;
            tmr_n = '0;
        end else if (psc_v == PSC_LAST) begin
            psc_n = '0;
            if (tmr_v != 16'hFFFF) begin
                tmr_n = tmr_v + 16'd1;
            end
        end else begin
            psc_n = psc_v + PW'(1);
        end
        // CLEAR wins over NXT_ADR; the address parks at NPAT+1 once the table is consumed.
        if (CLEAR) begin
            adr_n = '0;
        end else if (NXT_ADR && adr_v != ADR_END) begin
            adr_n = adr_v + AW'(1);
        end
        // DONE tracks the new address so it rises on the same edge as the final advance.
        done_n = (adr_n == ADR_END);
        // A LOAD_PAT after completion must not capture the don't-care ROM word.
        if (CLEAR) begin
            pat_n = '0;
        end else if (LOAD_PAT && !done_v) begin
            pat_n = rom_v;
        end
        leds_n = DISP ? pat_v : '0;
    end

    for (genvar g = 0; g < 3; g++) begin : gen_copy
        (* keep_hierarchy = "yes", dont_touch = "true" *)
        startup_pattern_rom #(
            .NPAT  (NPAT),
            .LED_W (LED_W),
            .AW    (AW)
        ) u_rom (
            .CLK   (CLK),
            .RST   (RST),
            .adr   (adr_v),
            .rom_q (rom_q[g])
        );

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                tmr_q[g]  <= '0;
                psc_q[g]  <= '0;
                adr_q[g]  <= '0;
                done_q[g] <= 1'b0;
                pat_q[g]  <= '0;
                leds_q[g] <= '0;
            end else begin
                tmr_q[g]  <= tmr_n;
                psc_q[g]  <= psc_n;
                adr_q[g]  <= adr_n;
                done_q[g] <= done_n;
                pat_q[g]  <= pat_n;
                leds_q[g] <= leds_n;
            end
        end
    end

    assign TMR  = tmr_v;
    assign DONE = done_v;
    assign LEDS = leds_v;

endmodule

// File: tb/tb_startup_display_engine.sv
// Purpose : self-checking bench for startup_display_engine (TICK_DIV=4 main instance, TICK_DIV=1 instance
//           for TMR saturation). Directed sequences, a table of load/complete/priority vectors, and
//           randomized strobes checked against a cycle-count/index reference model.
module tb_startup_display_engine;

    localparam int NPAT = 8;
    localparam int TD   = 4;

    logic        clk;
    logic        rst, clear, disp, load_pat, nxt_adr, rst_tmr;
    logic [15:0] tmr;
    logic        done;
    logic [7:0]  leds;

    logic        rst2;
    logic        z_clear, z_disp, z_load, z_nxt, rst_tmr2;
    logic [15:0] tmr2;
    logic        done2;
    logic [7:0]  leds2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int cyc_rel2;

    logic [7:0] rom_exp [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hA5};

    startup_display_engine #(.NPAT(NPAT), .LED_W(8), .TICK_DIV(TD)) dut (
        .CLK(clk), .RST(rst), .CLEAR(clear), .DISP(disp), .LOAD_PAT(load_pat),
        .NXT_ADR(nxt_adr), .RST_TMR(rst_tmr), .TMR(tmr), .DONE(done), .LEDS(leds)
    );

    startup_display_engine #(.NPAT(NPAT), .LED_W(8), .TICK_DIV(1)) dut_sat (
        .CLK(clk), .RST(rst2), .CLEAR(z_clear), .DISP(z_disp), .LOAD_PAT(z_load),
        .NXT_ADR(z_nxt), .RST_TMR(rst_tmr2), .TMR(tmr2), .DONE(done2), .LEDS(leds2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       c, d, l, n;
        logic       exp_done;
        logic [7:0] exp_leds;
    } vec_t;
    vec_t tbl[$];

    // Reference model state: cycles since RST_TMR low, address index, address one edge ago.
    int         m_cnt, m_adr, m_adr_prev;
    logic [7:0] m_pat, m_leds;
    bit         m_pat_ok, m_leds_ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic d, input logic l, input logic n, input logic r);
        clear = c; disp = d; load_pat = l; nxt_adr = n; rst_tmr = r;
    endtask

    task automatic add(input logic c, input logic d, input logic l, input logic n,
                       input logic ed, input logic [7:0] el);
        vec_t v;
        v.c = c; v.d = d; v.l = l; v.n = n; v.exp_done = ed; v.exp_leds = el;
        tbl.push_back(v);
    endtask

    // One edge of the reference model with the inputs the DUT samples on that edge.
    task automatic model_edge(input bit c, input bit d, input bit l, input bit n, input bit r);
        bit         romq_ok;
        bit         done_now;
        logic [7:0] romq;
        romq_ok  = (m_adr_prev >= 1 && m_adr_prev <= NPAT);
        romq     = romq_ok ? rom_exp[m_adr_prev - 1] : 8'h00;
        done_now = (m_adr == NPAT + 1);
        if (d) begin
            m_leds = m_pat; m_leds_ok = m_pat_ok;
        end else begin
            m_leds = 8'h00; m_leds_ok = 1'b1;
        end
        if (c) begin
            m_pat = 8'h00; m_pat_ok = 1'b1;
        end else if (l && !done_now) begin
            m_pat = romq; m_pat_ok = romq_ok;
        end
        m_adr_prev = m_adr;
        if (c)                        m_adr = 0;
        else if (n && m_adr < NPAT+1) m_adr = m_adr + 1;
        m_cnt = r ? 0 : m_cnt + 1;
    endtask

    initial begin
        int exp_t;
        rst = 1'b1; rst2 = 1'b1;
        drive(0, 0, 0, 0, 1);
        z_clear = 0; z_disp = 0; z_load = 0; z_nxt = 0; rst_tmr2 = 0;
        #12;
        chk("reset_tmr",  32'(tmr),  32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_leds", 32'(leds), 32'd0);
        step();
        rst = 1'b0; rst2 = 1'b0;
        cyc_rel2 = cyc;

        // Timer: first tick after TD edges, dwell value after 3000 ticks, RST_TMR clears on next edge.
        repeat (2) step();
        chk("tmr_held", 32'(tmr), 32'd0);
        rst_tmr = 0;
        repeat (3) step();
        chk("tmr_pre_tick", 32'(tmr), 32'd0);
        step();
        chk("tmr_first_tick", 32'(tmr), 32'd1);
        repeat (11995) step();
        chk("tmr_before_dwell", 32'(tmr), 32'hBB7);
        step();
        chk("tmr_dwell", 32'(tmr), 32'(startup_display_engine_pkg::DWELL_TICKS));
        rst_tmr = 1;
        step();
        chk("tmr_rst", 32'(tmr), 32'd0);

        // Table: 8 Next/Skip/Load triplets, completion, DISP blanking, CLEAR, CLEAR priority.
        for (int k = 0; k < NPAT; k++) begin
            logic [7:0] prev;
            prev = (k == 0) ? 8'h00 : rom_exp[k-1];
            add(0, 1, 0, 1, 0, prev);
            add(0, 1, 0, 0, 0, prev);
            add(0, 1, 1, 0, 0, prev);
        end
        add(0, 1, 0, 1, 1, rom_exp[7]);
        add(0, 1, 0, 0, 1, rom_exp[7]);
        add(0, 1, 1, 0, 1, rom_exp[7]);
        add(0, 1, 0, 0, 1, rom_exp[7]);
        add(0, 1, 0, 1, 1, rom_exp[7]);
        add(0, 1, 0, 1, 1, rom_exp[7]);
        add(0, 0, 0, 0, 1, 8'h00);
        add(0, 1, 0, 0, 1, rom_exp[7]);
        add(1, 1, 0, 0, 0, rom_exp[7]);
        add(0, 1, 0, 0, 0, 8'h00);
        add(0, 1, 0, 1, 0, 8'h00);
        add(0, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 0, 0, 8'h00);
        add(0, 1, 0, 0, 0, rom_exp[0]);
        add(1, 1, 1, 1, 0, rom_exp[0]);
        add(0, 1, 0, 0, 0, 8'h00);
        add(0, 1, 0, 1, 0, 8'h00);
        add(0, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 0, 0, 8'h00);
        add(0, 1, 0, 0, 0, rom_exp[0]);

        drive(1, 1, 0, 0, 1);
        step();
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].d, tbl[i].l, tbl[i].n, 1);
            step();
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].exp_done));
            chk($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].exp_leds));
            chk($sformatf("tbl%0d_tmr", i),  32'(tmr),  32'd0);
        end

        // Asynchronous reset mid-sequence with ADR=5, LEDS showing ROM[4], TMR running.
        drive(1, 1, 0, 0, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 1, 0);
            step();
        end
        drive(0, 1, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0); step();
        drive(0, 1, 0, 0, 0); step();
        chk("pre_rst_leds", 32'(leds), 32'(rom_exp[4]));
        chk("pre_rst_tmr",  32'(tmr),  32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tmr",  32'(tmr),  32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_leds", 32'(leds), 32'd0);
        step();
        rst = 1'b0;
        drive(0, 1, 0, 0, 1);
        step();
        chk("post_rst_tmr",  32'(tmr),  32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_leds", 32'(leds), 32'd0);

        // Randomized strobes against the reference model.
        m_cnt = 0; m_adr = 0; m_adr_prev = 0;
        m_pat = 8'h00; m_pat_ok = 1'b1; m_leds = 8'h00; m_leds_ok = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit c, d, l, n, r;
            c = ($urandom_range(0, 99) < 4);
            d = ($urandom_range(0, 99) < 80);
            l = ($urandom_range(0, 99) < 35);
            n = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 2);
            drive(c, d, l, n, r);
            model_edge(c, d, l, n, r);
            step();
            exp_t = (m_cnt / TD > 65535) ? 65535 : m_cnt / TD;
            chk("rnd_tmr",  32'(tmr),  32'(exp_t));
            chk("rnd_done", 32'(done), 32'(m_adr == NPAT + 1));
            if (m_leds_ok) chk("rnd_leds", 32'(leds), 32'(m_leds));
        end

        // Saturation on the TICK_DIV=1 instance: one tick per edge, sticks at all-ones.
        exp_t = cyc - cyc_rel2;
        chk("sat_count", 32'(tmr2), 32'((exp_t > 65535) ? 65535 : exp_t));
        while (cyc - cyc_rel2 < 65535 + 20) step();
        chk("sat_reach", 32'(tmr2), 32'hFFFF);
        repeat (50) step();
        chk("sat_hold", 32'(tmr2), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
